// File: rtl/axi_mem_responder_if.sv
// AXI3-style bus bundle between the NES core master port and the byte-wide memory responder.
// The slave modport is the memory side; the master modport is the driving side.
interface axi_mem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [ID_WIDTH-1:0]     awid;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [ID_WIDTH-1:0]     wid;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic [ID_WIDTH-1:0]     bid;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [ID_WIDTH-1:0]     arid;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [ID_WIDTH-1:0]     rid;
  logic                    rlast;
  logic                    rvalid;
  logic [1:0]              rresp;
  logic                    rready;

  modport slave (
    input  awaddr, awid, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wid, wstrb, wlast, wvalid,
    output wready,
    output bresp, bid, bvalid,
    input  bready,
    input  araddr, arid, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rid, rlast, rvalid, rresp,
    input  rready
  );

  modport master (
    output awaddr, awid, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wid, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bid, bvalid,
    output bready,
    output araddr, arid, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rid, rlast, rvalid, rresp,
    output rready
  );
endinterface

// File: rtl/axi_mem_responder.sv
// Byte-wide AXI3-style slave memory with independent one-outstanding read and write FSMs.
// Write: W_IDLE (accept AW) -> W_DATA (take beats) -> W_RESP (hold B). Read: R_IDLE -> R_FETCH -> R_DATA.
module axi_mem_responder #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    ID_WIDTH       = 4,
  parameter int                    MEM_ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 rst,
  axi_mem_responder_if.slave  axi_slave
);

  localparam int         DEPTH       = 1 << MEM_ADDR_WIDTH;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  w_state_e              w_state_q;
  logic [ADDR_WIDTH-1:0] w_addr_q;
  logic [ID_WIDTH-1:0]   w_id_q;
  logic [7:0]            w_len_q;
  logic [7:0]            w_cnt_q;
  logic [1:0]            w_burst_q;
  logic                  w_slv_q;
  logic                  w_dec_q;
  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic [ID_WIDTH-1:0]   bid_q;

  r_state_e              r_state_q;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [ID_WIDTH-1:0]   r_id_q;
  logic [7:0]            r_len_q;
  logic [7:0]            r_cnt_q;
  logic [1:0]            r_burst_q;
  logic                  r_err_q;
  logic                  arready_q;
  logic                  rvalid_q;
  logic                  rlast_q;
  logic [1:0]            rresp_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [ADDR_WIDTH-1:0] w_off;
  logic [ADDR_WIDTH-1:0] r_off;
  logic                  w_in_range;
  logic                  r_in_range;
  logic                  w_last_beat;
  logic                  w_beat_slv;
  logic                  w_fire;
  logic                  w_we;

  // Unsigned offset from the base: addresses below the base wrap high and decode out of range.
  assign w_off       = w_addr_q - BASE_ADDR;
  assign r_off       = r_addr_q - BASE_ADDR;
  assign w_in_range  = (w_off[ADDR_WIDTH-1:MEM_ADDR_WIDTH] == '0);
  assign r_in_range  = (r_off[ADDR_WIDTH-1:MEM_ADDR_WIDTH] == '0);
  assign w_last_beat = (w_cnt_q == w_len_q);
  assign w_beat_slv  = w_slv_q | (axi_slave.wid != w_id_q) | (axi_slave.wlast != w_last_beat);
  assign w_fire      = (w_state_q == W_DATA) & axi_slave.wvalid & wready_q;
  assign w_we        = w_fire & axi_slave.wstrb[0] & w_in_range & ~w_beat_slv & ~rst;

  always_ff @(posedge clk) begin
    if (w_we) mem_q[w_off[MEM_ADDR_WIDTH-1:0]] <= axi_slave.wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_id_q    <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_burst_q <= '0;
      w_slv_q   <= 1'b0;
      w_dec_q   <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bid_q     <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (axi_slave.awvalid && awready_q) begin
            w_addr_q  <= axi_slave.awaddr;
            w_id_q    <= axi_slave.awid;
            w_len_q   <= axi_slave.awlen;
            w_burst_q <= axi_slave.awburst;
            w_cnt_q   <= '0;
            w_slv_q   <= axi_slave.awburst[1] | (axi_slave.awsize != 3'd0);
            w_dec_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_slv_q <= w_beat_slv;
            w_dec_q <= w_dec_q | ~w_in_range;
            if (w_burst_q != BURST_FIXED) w_addr_q <= w_addr_q + 1'b1;
            // The beat count alone ends the burst; a stray wlast only raises SLVERR.
            if (w_last_beat) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bid_q     <= w_id_q;
              bresp_q   <= (w_dec_q | ~w_in_range) ? RESP_DECERR :
                           w_beat_slv              ? RESP_SLVERR : RESP_OKAY;
              w_state_q <= W_RESP;
            end else begin
              w_cnt_q <= w_cnt_q + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (axi_slave.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_id_q    <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_burst_q <= '0;
      r_err_q   <= 1'b0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rid_q     <= '0;
      rdata_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (axi_slave.arvalid && arready_q) begin
            r_addr_q  <= axi_slave.araddr;
            r_id_q    <= axi_slave.arid;
            r_len_q   <= axi_slave.arlen;
            r_burst_q <= axi_slave.arburst;
            r_cnt_q   <= '0;
            r_err_q   <= axi_slave.arburst[1] | (axi_slave.arsize != 3'd0);
            arready_q <= 1'b0;
            r_state_q <= R_FETCH;
          end
        end
        R_FETCH: begin
          // Non-blocking read of mem_q gives read-first ordering against a same-edge write.
          rdata_q   <= r_in_range ? mem_q[r_off[MEM_ADDR_WIDTH-1:0]] : '0;
          rresp_q   <= ~r_in_range ? RESP_DECERR : r_err_q ? RESP_SLVERR : RESP_OKAY;
          rlast_q   <= (r_cnt_q == r_len_q);
          rid_q     <= r_id_q;
          rvalid_q  <= 1'b1;
          r_state_q <= R_DATA;
        end
        R_DATA: begin
          if (axi_slave.rready) begin
            rvalid_q <= 1'b0;
            if (rlast_q) begin
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= R_IDLE;
            end else begin
              if (r_burst_q != BURST_FIXED) r_addr_q <= r_addr_q + 1'b1;
              r_cnt_q   <= r_cnt_q + 8'd1;
              r_state_q <= R_FETCH;
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign axi_slave.awready = awready_q;
  assign axi_slave.wready  = wready_q;
  assign axi_slave.bvalid  = bvalid_q;
  assign axi_slave.bresp   = bresp_q;
  assign axi_slave.bid     = bid_q;
  assign axi_slave.arready = arready_q;
  assign axi_slave.rvalid  = rvalid_q;
  assign axi_slave.rlast   = rlast_q;
  assign axi_slave.rresp   = rresp_q;
  assign axi_slave.rid     = rid_q;
  assign axi_slave.rdata   = rdata_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Bench for axi_mem_responder: directed and random bursts checked against a byte-array model.
module tb_axi_mem_responder;
  localparam int          AW    = 32;
  localparam int          IW    = 4;
  localparam int          DW    = 8;
  localparam int          MAW   = 12;
  localparam int          DEPTH = 1 << MAW;
  localparam logic [31:0] BASE  = 32'h0000_8000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_mem_responder_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

  axi_mem_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_ADDR_WIDTH(MAW), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .axi_slave(bus)
  );

  logic [7:0] model [DEPTH];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    logic [31:0] d;
    d = a - BASE;
    return d < 32'(DEPTH);
  endfunction

  function automatic int idx(input logic [31:0] a);
    logic [31:0] d;
    d = a - BASE;
    return int'(d % 32'(DEPTH));
  endfunction

  // wlast_mode: 0 = wlast on final beat only, 1 = wlast never, 2 = wlast on every beat.
  // strb_mode: 0 = all on, 1 = all off, 2 = random. d0 < 0 selects random data.
  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input int len,
                          input logic [1:0] burst, input logic [2:0] size, input int strb_mode,
                          input int wlast_mode, input int bad_wid_beat, input int d0,
                          input int dstep, input int bstall, input string tag);
    logic [7:0]  dq  [256];
    logic        sq  [256];
    logic        wlq [256];
    logic [3:0]  wq  [256];
    logic [31:0] a;
    logic [1:0]  exp_resp;
    bit          slv;
    bit          dec;
    int          t;
    slv = burst[1] || (size != 3'd0);
    dec = 0;
    a   = addr;
    for (int i = 0; i <= len; i++) begin
      dq[i]  = (d0 < 0) ? 8'($urandom) : 8'(d0 + i * dstep);
      sq[i]  = (strb_mode == 0) ? 1'b1 : (strb_mode == 1) ? 1'b0 : 1'($urandom);
      wlq[i] = (wlast_mode == 1) ? 1'b0 : (wlast_mode == 2) ? 1'b1 : (i == len);
      wq[i]  = (i == bad_wid_beat) ? ~id : id;
      if ((i == bad_wid_beat) || (wlq[i] != (i == len))) slv = 1;
      if (!in_rng(a)) dec = 1;
      else if (sq[i] && !slv) model[idx(a)] = dq[i];
      if (burst != 2'b00) a = a + 1;
    end
    exp_resp = dec ? 2'b11 : slv ? 2'b10 : 2'b00;

    bus.awaddr = addr; bus.awid = id; bus.awlen = 8'(len);
    bus.awsize = size; bus.awburst = burst; bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < 50) begin tick(); t++; end
    check({tag, ".aw_timeout"}, 32'(t < 50), 32'd1);
    tick();
    bus.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if ($urandom_range(0, 3) == 0) begin bus.wvalid = 1'b0; tick(); end
      bus.wdata = dq[i]; bus.wid = wq[i]; bus.wstrb = sq[i]; bus.wlast = wlq[i];
      bus.wvalid = 1'b1;
      t = 0;
      while (!bus.wready && t < 50) begin tick(); t++; end
      tick();
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    t = 0;
    while (!bus.bvalid && t < 50) begin tick(); t++; end
    check({tag, ".bvalid"}, 32'(bus.bvalid), 32'd1);
    check({tag, ".bid"}, 32'(bus.bid), 32'(id));
    check({tag, ".bresp"}, 32'(bus.bresp), 32'(exp_resp));
    for (int k = 0; k < bstall; k++) begin
      tick();
      check({tag, ".bvalid_hold"}, 32'(bus.bvalid), 32'd1);
      check({tag, ".bresp_hold"}, 32'(bus.bresp), 32'(exp_resp));
      check({tag, ".awready_low"}, 32'(bus.awready), 32'd0);
    end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    check({tag, ".bvalid_drop"}, 32'(bus.bvalid), 32'd0);
    check({tag, ".awready_back"}, 32'(bus.awready), 32'd1);
  endtask

  // stall: 0 = accept at once, >0 = that many wait cycles per beat, <0 = random 0..3.
  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input int len,
                         input logic [1:0] burst, input logic [2:0] size, input int stall,
                         input string tag);
    logic [31:0] a;
    logic [7:0]  ed;
    logic [1:0]  er;
    logic [7:0]  hold_d;
    bit          err;
    int          t;
    int          ns;
    err = burst[1] || (size != 3'd0);
    a   = addr;
    bus.araddr = addr; bus.arid = id; bus.arlen = 8'(len);
    bus.arsize = size; bus.arburst = burst; bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < 50) begin tick(); t++; end
    check({tag, ".ar_timeout"}, 32'(t < 50), 32'd1);
    tick();
    bus.arvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      t = 0;
      while (!bus.rvalid && t < 10) begin tick(); t++; end
      check({tag, ".r_latency"}, 32'(t), 32'd1);
      ed = in_rng(a) ? model[idx(a)] : 8'h00;
      er = !in_rng(a) ? 2'b11 : err ? 2'b10 : 2'b00;
      check({tag, ".rdata"}, 32'(bus.rdata), 32'(ed));
      check({tag, ".rresp"}, 32'(bus.rresp), 32'(er));
      check({tag, ".rlast"}, 32'(bus.rlast), 32'(i == len));
      check({tag, ".rid"}, 32'(bus.rid), 32'(id));
      ns = (stall < 0) ? $urandom_range(0, 3) : stall;
      hold_d = bus.rdata;
      for (int k = 0; k < ns; k++) begin
        tick();
        check({tag, ".rvalid_hold"}, 32'(bus.rvalid), 32'd1);
        check({tag, ".rdata_hold"}, 32'(bus.rdata), 32'(hold_d));
        check({tag, ".rlast_hold"}, 32'(bus.rlast), 32'(i == len));
      end
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
      if (burst != 2'b00) a = a + 1;
    end
    check({tag, ".rvalid_end"}, 32'(bus.rvalid), 32'd0);
    check({tag, ".arready_end"}, 32'(bus.arready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".awready"}, 32'(bus.awready), 32'd1);
    check({tag, ".arready"}, 32'(bus.arready), 32'd1);
    check({tag, ".wready"}, 32'(bus.wready), 32'd0);
    check({tag, ".bvalid"}, 32'(bus.bvalid), 32'd0);
    check({tag, ".rvalid"}, 32'(bus.rvalid), 32'd0);
    check({tag, ".rlast"}, 32'(bus.rlast), 32'd0);
    check({tag, ".bresp"}, 32'(bus.bresp), 32'd0);
    check({tag, ".rresp"}, 32'(bus.rresp), 32'd0);
    check({tag, ".bid"}, 32'(bus.bid), 32'd0);
    check({tag, ".rid"}, 32'(bus.rid), 32'd0);
    check({tag, ".rdata"}, 32'(bus.rdata), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  old_b;
    logic [7:0]  new_b;
    logic [3:0]  rid_r;
    int          len_r;
    logic [1:0]  burst_r;
    logic [2:0]  size_r;
    int          sel;

    rst = 1'b1;
    bus.awaddr = '0; bus.awid = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0; bus.wdata = '0; bus.wid = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arid = '0; bus.arlen = '0;
    bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Fill the whole memory with 256-beat bursts so every later read has a known value.
    for (int b = 0; b < DEPTH / 256; b++)
      do_write(BASE + 32'(b * 256), 4'(b), 255, 2'b01, 3'd0, 0, 0, -1, -1, 0, 0, "preload");

    do_write(BASE + 32'h10, 4'd5, 3, 2'b01, 3'd0, 0, 0, -1, 'hA1, 1, 0, "wr_incr");
    do_read (BASE + 32'h10, 4'd5, 3, 2'b01, 3'd0, 0, "rd_incr");
    do_write(BASE + 32'h20, 4'd7, 2, 2'b00, 3'd0, 0, 0, -1, 'h11, 'h11, 0, "wr_fixed");
    do_read (BASE + 32'h20, 4'd7, 0, 2'b01, 3'd0, 0, "rd_fixed");
    do_read (BASE + 32'h20, 4'd2, 3, 2'b00, 3'd0, 0, "rd_fixed_burst");
    do_write(BASE + 32'hFFF, 4'd1, 1, 2'b01, 3'd0, 0, 0, -1, -1, 0, 0, "wr_top_edge");
    do_read (BASE + 32'hFFF, 4'd1, 1, 2'b01, 3'd0, 0, "rd_top_edge");
    do_write(BASE - 32'd1, 4'd9, 1, 2'b01, 3'd0, 0, 0, -1, -1, 0, 0, "wr_below_base");
    do_read (BASE - 32'd1, 4'd9, 1, 2'b01, 3'd0, 0, "rd_below_base");
    do_write(BASE + 32'h40, 4'd3, 0, 2'b01, 3'd0, 0, 1, -1, -1, 0, 0, "wr_nolast");
    do_write(BASE + 32'h48, 4'd3, 3, 2'b01, 3'd0, 0, 2, -1, -1, 0, 0, "wr_earlylast");
    do_write(BASE + 32'h50, 4'd4, 3, 2'b01, 3'd0, 1, 0, -1, -1, 0, 0, "wr_nostrb");
    do_write(BASE + 32'h58, 4'd6, 3, 2'b01, 3'd0, 0, 0, 1, -1, 0, 0, "wr_badwid");
    do_write(BASE + 32'h60, 4'd8, 2, 2'b10, 3'd0, 0, 0, -1, -1, 0, 0, "wr_wrap");
    do_write(BASE + 32'h68, 4'd8, 1, 2'b01, 3'd1, 0, 0, -1, -1, 0, 0, "wr_size");
    do_read (BASE + 32'h40, 4'd2, 47, 2'b01, 3'd0, 0, "rd_err_area");
    do_read (BASE + 32'h60, 4'd2, 2, 2'b11, 3'd0, 0, "rd_reserved");
    do_read (BASE + 32'h60, 4'd2, 1, 2'b01, 3'd2, 0, "rd_size");
    do_read (BASE + 32'h80, 4'd11, 7, 2'b01, 3'd0, 3, "rd_stall");
    do_write(BASE + 32'h90, 4'd12, 1, 2'b01, 3'd0, 0, 0, -1, -1, 0, 10, "wr_bstall");
    do_read (BASE + 32'h300, 4'd13, 255, 2'b01, 3'd0, 0, "rd_len255");

    for (int n = 0; n < 24; n++) begin
      a     = BASE + 32'($urandom_range(0, DEPTH + 100)) - 32'd50;
      len_r = $urandom_range(0, 15);
      sel   = $urandom_range(0, 7);
      burst_r = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b10 : (sel == 2) ? 2'b11 : 2'b01;
      size_r  = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd0;
      rid_r   = 4'($urandom);
      do_write(a, rid_r, len_r, burst_r, size_r, $urandom_range(0, 2),
               ($urandom_range(0, 7) == 0) ? 1 : 0,
               ($urandom_range(0, 7) == 0) ? 0 : -1, -1, 0, $urandom_range(0, 2), "wr_rand");
      do_read(a, ~rid_r, len_r, 2'b01, 3'd0, -1, "rd_rand");
    end

    // AW and AR accepted on the same edge; the write and the fetch then share an edge.
    a     = BASE + 32'h300;
    old_b = model[idx(a)];
    new_b = old_b ^ 8'h5A;
    bus.awaddr = a; bus.awid = 4'd3; bus.awlen = 8'd0; bus.awsize = 3'd0; bus.awburst = 2'b01;
    bus.araddr = a; bus.arid = 4'd6; bus.arlen = 8'd0; bus.arsize = 3'd0; bus.arburst = 2'b01;
    bus.wdata = new_b; bus.wid = 4'd3; bus.wstrb = 1'b1; bus.wlast = 1'b1;
    bus.awvalid = 1'b1; bus.arvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    check("conc.awready", 32'(bus.awready), 32'd1);
    check("conc.arready", 32'(bus.arready), 32'd1);
    tick();
    bus.awvalid = 1'b0; bus.arvalid = 1'b0;
    check("conc.aw_taken", 32'(bus.awready), 32'd0);
    check("conc.ar_taken", 32'(bus.arready), 32'd0);
    check("conc.wready", 32'(bus.wready), 32'd1);
    tick();
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check("conc.rvalid", 32'(bus.rvalid), 32'd1);
    check("conc.rdata_old", 32'(bus.rdata), 32'(old_b));
    check("conc.bvalid", 32'(bus.bvalid), 32'd1);
    check("conc.bresp", 32'(bus.bresp), 32'd0);
    model[idx(a)] = new_b;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0; bus.bready = 1'b0;
    do_read(a, 4'd6, 0, 2'b01, 3'd0, 0, "conc_after");

    // Reset after two of four beats: beats 3 and 4 must never reach memory.
    a = BASE + 32'h400;
    bus.awaddr = a; bus.awid = 4'd2; bus.awlen = 8'd3; bus.awsize = 3'd0; bus.awburst = 2'b01;
    bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.wdata = 8'($urandom); bus.wid = 4'd2; bus.wstrb = 1'b1; bus.wlast = 1'b0;
      bus.wvalid = 1'b1;
      check("rstmid.wready", 32'(bus.wready), 32'd1);
      model[idx(a + 32'(i))] = bus.wdata;
      tick();
    end
    bus.wdata = ~model[idx(a + 32'd2)];
    rst = 1'b1;
    tick();
    check_reset_outputs("rstmid");
    rst = 1'b0;
    bus.wdata = ~model[idx(a + 32'd3)]; bus.wlast = 1'b1;
    tick();
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check("rstmid.no_bvalid", 32'(bus.bvalid), 32'd0);
    do_read(a, 4'd2, 3, 2'b01, 3'd0, 0, "rstmid_rd");
    do_write(BASE + 32'h500, 4'd14, 3, 2'b01, 3'd0, 0, 0, -1, -1, 0, 0, "fresh_wr");
    do_read (BASE + 32'h500, 4'd14, 3, 2'b01, 3'd0, -1, "fresh_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
